// File: rtl/noc_input_vc_requester_pkg.sv
// Shared definitions for the router input-port requester.
// Holds the default channel count and coordinate width, the output-port
// index type and constants, and the dimension-order XY route function.
// Every input port uses this one route function so they all make the same
// routing decision for the same destination.
package noc_input_vc_requester_pkg;

    localparam int Noc_VC_Channel  = 2;
    localparam int Noc_Coord_Width = 4;
    localparam int NUM_PORTS       = 5;

    typedef logic [2:0] port_t;

    localparam port_t PORT_LOCAL = 3'd0;
    localparam port_t PORT_EAST  = 3'd1;
    localparam port_t PORT_WEST  = 3'd2;
    localparam port_t PORT_NORTH = 3'd3;
    localparam port_t PORT_SOUTH = 3'd4;

    // XY routing: resolve X first, then Y, all comparisons unsigned.
    // Coordinates are passed zero-extended to 32 bits so that one function
    // serves any coordinate width up to 32.
    function automatic port_t xy_route(
        input logic [31:0] dest_x,
        input logic [31:0] dest_y,
        input logic [31:0] local_x,
        input logic [31:0] local_y
    );
        port_t port_v;
        if (dest_x > local_x) begin
            port_v = PORT_EAST;
        end else if (dest_x < local_x) begin
            port_v = PORT_WEST;
        end else if (dest_y > local_y) begin
            port_v = PORT_NORTH;
        end else if (dest_y < local_y) begin
            port_v = PORT_SOUTH;
        end else begin
            port_v = PORT_LOCAL;
        end
        return port_v;
    endfunction

    // One-hot decode of a port index onto the five output ports.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_t port_idx);
        logic [NUM_PORTS-1:0] oh_v;
        case (port_idx)
            PORT_LOCAL: oh_v = 5'b00001;
            PORT_EAST:  oh_v = 5'b00010;
            PORT_WEST:  oh_v = 5'b00100;
            PORT_NORTH: oh_v = 5'b01000;
            PORT_SOUTH: oh_v = 5'b10000;
            default:    oh_v = 5'b00000;
        endcase
        return oh_v;
    endfunction

endpackage

// File: rtl/noc_input_vc_requester_fsm.sv
// Per-VC request FSM (module noc_vc_request_fsm).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid, head, tail     status of the flit at the head of this VC's buffer
//   dest_x, dest_y        destination of the header flit
//   grant[p]              output port p accepts a flit from this VC
//   pop                   pop this VC's buffer (granted flit or dropped flit)
//   drop                  a non-header flit was discarded while idle
//   req                   a flit is ready for the owned port
//   eop                   the tail flit leaves this cycle (also the VC release)
//   sop[p]                registered one-hot: this VC holds a packet for port p
//   port                  registered owned port index (crossbar select)
module noc_vc_request_fsm
    import noc_input_vc_requester_pkg::*;
#(
    parameter int COORD_W = Noc_Coord_Width,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 head,
    input  logic                 tail,
    input  logic [COORD_W-1:0]   dest_x,
    input  logic [COORD_W-1:0]   dest_y,
    input  logic [NUM_PORTS-1:0] grant,
    output logic                 pop,
    output logic                 drop,
    output logic                 req,
    output logic                 eop,
    output logic [NUM_PORTS-1:0] sop,
    output port_t                port
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]           state_r;
    logic [0:0]           state_nxt_s;
    port_t                port_r;
    port_t                port_nxt_s;
    logic [NUM_PORTS-1:0] sop_r;
    logic [NUM_PORTS-1:0] sop_nxt_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 req_s;
    logic                 eop_s;
    logic                 grant_sel_s;
    logic [7:0]           grant_pad_s;

    // Pad the grant vector so any 3-bit port index selects a defined bit.
    assign grant_pad_s = {3'b000, grant};

    // Next-state, request and pop decode for one VC.
    always_comb begin
        state_nxt_s = state_r;
        port_nxt_s  = port_r;
        pop_s       = 1'b0;
        drop_s      = 1'b0;
        req_s       = 1'b0;
        eop_s       = 1'b0;
        grant_sel_s = grant_pad_s[port_r];
        case (state_r)
            ST_IDLE: begin
                if (valid && head) begin
                    state_nxt_s = ST_ACTIVE;
                    port_nxt_s  = xy_route(32'(dest_x), 32'(dest_y),
                                           32'(LOCAL_X), 32'(LOCAL_Y));
                end else if (valid) begin
                    // A body flit with no owning packet cannot be routed.
                    pop_s  = 1'b1;
                    drop_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                req_s = valid;
                pop_s = valid && grant_sel_s;
                if (pop_s && tail) begin
                    eop_s       = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // start_of_packet is held as a registered one-hot of the owned port.
        if (state_nxt_s == ST_ACTIVE) begin
            sop_nxt_s = port_onehot(port_nxt_s);
        end else begin
            sop_nxt_s = 5'b00000;
        end
    end

    // State, owned port and registered start_of_packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            port_r  <= PORT_LOCAL;
            sop_r   <= 5'b00000;
        end else begin
            state_r <= state_nxt_s;
            port_r  <= port_nxt_s;
            sop_r   <= sop_nxt_s;
        end
    end

    // Combinational outputs are forced low while reset is held so that a
    // body flit sitting in the buffer is not dropped during reset.
    assign pop  = pop_s  & rst_n;
    assign drop = drop_s & rst_n;
    assign req  = req_s  & rst_n;
    assign eop  = eop_s  & rst_n;
    assign sop  = sop_r;
    assign port = port_r;

endmodule

// File: rtl/noc_input_vc_requester.sv
// Input-port requester for the router switch-allocation handshake.
// Ports:
//   noc_clk, noc_rst_n        clock, asynchronous active-low reset
//   vc_valid/head/tail[c]     head-flit status of VC buffer c
//   vc_dest_x/y[c]            header destination of VC c
//   vc_pop[c]                 pop VC buffer c this cycle
//   vc_port[c]                output port owned by VC c (crossbar select)
//   start_of_packet[p][c]     VC c holds a packet routed to port p
//   end_of_packet[p][c]       tail of VC c leaves toward port p this cycle
//   request[p][c]             VC c has a flit ready for port p
//   free[p][c]                VC c releases its VC grant at port p
//   grant[p][c]               port p accepts one flit from VC c
//   drop_o[c]                 a non-header flit was discarded while idle
module noc_input_vc_requester
    import noc_input_vc_requester_pkg::*;
#(
    parameter int CHANNELS = Noc_VC_Channel,
    parameter int COORD_W  = Noc_Coord_Width,
    parameter int LOCAL_X  = 0,
    parameter int LOCAL_Y  = 0
) (
    input  logic                               noc_clk,
    input  logic                               noc_rst_n,
    input  logic [CHANNELS-1:0]                vc_valid,
    input  logic [CHANNELS-1:0]                vc_head,
    input  logic [CHANNELS-1:0]                vc_tail,
    input  logic [CHANNELS-1:0][COORD_W-1:0]   vc_dest_x,
    input  logic [CHANNELS-1:0][COORD_W-1:0]   vc_dest_y,
    output logic [CHANNELS-1:0]                vc_pop,
    output logic [CHANNELS-1:0][2:0]           vc_port,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] start_of_packet,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] end_of_packet,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] request,
    output logic [NUM_PORTS-1:0][CHANNELS-1:0] free,
    input  logic [NUM_PORTS-1:0][CHANNELS-1:0] grant,
    output logic [CHANNELS-1:0]                drop_o
);

    logic [CHANNELS-1:0][NUM_PORTS-1:0] vc_sop_s;
    logic [CHANNELS-1:0][NUM_PORTS-1:0] grant_col_s;
    logic [CHANNELS-1:0]                vc_req_s;
    logic [CHANNELS-1:0]                vc_eop_s;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
        // Gather the grant column for VC c across the five ports.
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_grant
            assign grant_col_s[c][p] = grant[p][c];
        end

        noc_vc_request_fsm #(
            .COORD_W (COORD_W),
            .LOCAL_X (LOCAL_X),
            .LOCAL_Y (LOCAL_Y)
        ) u_fsm (
            .clk    (noc_clk),
            .rst_n  (noc_rst_n),
            .valid  (vc_valid[c]),
            .head   (vc_head[c]),
            .tail   (vc_tail[c]),
            .dest_x (vc_dest_x[c]),
            .dest_y (vc_dest_y[c]),
            .grant  (grant_col_s[c]),
            .pop    (vc_pop[c]),
            .drop   (drop_o[c]),
            .req    (vc_req_s[c]),
            .eop    (vc_eop_s[c]),
            .sop    (vc_sop_s[c]),
            .port   (vc_port[c])
        );

        // Fan per-VC signals out to the owned port only; the one-hot sop
        // keeps every other port's bit at zero.
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fan
            assign start_of_packet[p][c] = vc_sop_s[c][p];
            assign request[p][c]         = vc_req_s[c] & vc_sop_s[c][p];
            assign end_of_packet[p][c]   = vc_eop_s[c] & vc_sop_s[c][p];
            assign free[p][c]            = vc_eop_s[c] & vc_sop_s[c][p];
        end
    end

endmodule

// File: tb/tb_noc_input_vc_requester.sv
module tb_noc_input_vc_requester;

    localparam int CH = 2;
    localparam int CW = 4;
    localparam int LX = 1;
    localparam int LY = 1;

    logic                  noc_clk = 1'b0;
    logic                  noc_rst_n;
    logic [CH-1:0]         vc_valid, vc_head, vc_tail;
    logic [CH-1:0][CW-1:0] vc_dest_x, vc_dest_y;
    logic [CH-1:0]         vc_pop, drop_o;
    logic [CH-1:0][2:0]    vc_port;
    logic [4:0][CH-1:0]    start_of_packet, end_of_packet, request, free, grant;

    noc_input_vc_requester #(
        .CHANNELS (CH), .COORD_W (CW), .LOCAL_X (LX), .LOCAL_Y (LY)
    ) dut (
        .noc_clk         (noc_clk),
        .noc_rst_n       (noc_rst_n),
        .vc_valid        (vc_valid),
        .vc_head         (vc_head),
        .vc_tail         (vc_tail),
        .vc_dest_x       (vc_dest_x),
        .vc_dest_y       (vc_dest_y),
        .vc_pop          (vc_pop),
        .vc_port         (vc_port),
        .start_of_packet (start_of_packet),
        .end_of_packet   (end_of_packet),
        .request         (request),
        .free            (free),
        .grant           (grant),
        .drop_o          (drop_o)
    );

    always #5 noc_clk = ~noc_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per VC, whether it owns a packet and which port.
    bit own [CH];
    int mport [CH];
    logic [4:0][CH-1:0] e_sop, e_req, e_eop;
    logic [CH-1:0]      e_pop, e_drop;
    logic [CH-1:0][2:0] e_port;

    // Packet driver state for the directed sequences.
    int         pk_len [CH];
    int         pk_idx [CH];
    logic [3:0] pk_dx [CH];
    logic [3:0] pk_dy [CH];

    typedef struct { logic [3:0] dx; logic [3:0] dy; int port; } route_vec_t;
    typedef struct { logic sop; logic pop; logic eop; } cyc_vec_t;
    typedef struct { logic req; logic pop; } single_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_route(input int dx, input int dy);
        if (dx > LX) return 1;
        if (dx < LX) return 2;
        if (dy > LY) return 3;
        if (dy < LY) return 4;
        return 0;
    endfunction

    // Let inputs settle, predict every output from the model, compare.
    task automatic settle_check();
        #2;
        e_sop = '0; e_req = '0; e_eop = '0; e_pop = '0; e_drop = '0; e_port = '0;
        if (!noc_rst_n) begin
            for (int c = 0; c < CH; c++) begin
                own[c]   = 1'b0;
                mport[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                e_port[c] = 3'(mport[c]);
                if (own[c]) begin
                    e_sop[mport[c]][c] = 1'b1;
                    if (vc_valid[c]) begin
                        e_req[mport[c]][c] = 1'b1;
                        if (grant[mport[c]][c]) begin
                            e_pop[c] = 1'b1;
                            if (vc_tail[c]) e_eop[mport[c]][c] = 1'b1;
                        end
                    end
                end else if (vc_valid[c] && !vc_head[c]) begin
                    e_pop[c]  = 1'b1;
                    e_drop[c] = 1'b1;
                end
            end
        end
        chk("sop",     32'(start_of_packet), 32'(e_sop));
        chk("request", 32'(request),         32'(e_req));
        chk("eop",     32'(end_of_packet),   32'(e_eop));
        chk("free",    32'(free),            32'(e_eop));
        chk("pop",     32'(vc_pop),          32'(e_pop));
        chk("drop",    32'(drop_o),          32'(e_drop));
        chk("vc_port", 32'(vc_port),         32'(e_port));
    endtask

    // Update the model for the clock edge, then move to just after it.
    task automatic advance();
        if (noc_rst_n) begin
            for (int c = 0; c < CH; c++) begin
                if (!own[c] && vc_valid[c] && vc_head[c]) begin
                    own[c]   = 1'b1;
                    mport[c] = ref_route(int'(vc_dest_x[c]), int'(vc_dest_y[c]));
                end else if (own[c] && e_pop[c] && vc_tail[c]) begin
                    own[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (e_pop[c]) pk_idx[c]++;
        end
        @(posedge noc_clk);
        #1;
    endtask

    task automatic tick();
        settle_check();
        advance();
    endtask

    task automatic start_pk(input int c, input int len, input logic [3:0] dx, input logic [3:0] dy);
        pk_len[c] = len;
        pk_idx[c] = 0;
        pk_dx[c]  = dx;
        pk_dy[c]  = dy;
    endtask

    task automatic apply_pk();
        for (int c = 0; c < CH; c++) begin
            vc_dest_x[c] = pk_dx[c];
            vc_dest_y[c] = pk_dy[c];
            if (pk_idx[c] < pk_len[c]) begin
                vc_valid[c] = 1'b1;
                vc_head[c]  = (pk_idx[c] == 0);
                vc_tail[c]  = (pk_idx[c] == pk_len[c] - 1);
            end else begin
                vc_valid[c] = 1'b0;
                vc_head[c]  = 1'b0;
                vc_tail[c]  = 1'b0;
            end
        end
    endtask

    route_vec_t  rt [4];
    cyc_vec_t    t1 [5];
    single_vec_t t3 [5];

    initial begin
        rt[0] = '{dx: 4'd0, dy: 4'd1, port: 2};
        rt[1] = '{dx: 4'd1, dy: 4'd3, port: 3};
        rt[2] = '{dx: 4'd1, dy: 4'd0, port: 4};
        rt[3] = '{dx: 4'd1, dy: 4'd1, port: 0};
        t1[0] = '{sop: 1'b0, pop: 1'b0, eop: 1'b0};
        t1[1] = '{sop: 1'b1, pop: 1'b1, eop: 1'b0};
        t1[2] = '{sop: 1'b1, pop: 1'b1, eop: 1'b0};
        t1[3] = '{sop: 1'b1, pop: 1'b1, eop: 1'b1};
        t1[4] = '{sop: 1'b0, pop: 1'b0, eop: 1'b0};
        t3[0] = '{req: 1'b0, pop: 1'b0};
        t3[1] = '{req: 1'b1, pop: 1'b0};
        t3[2] = '{req: 1'b1, pop: 1'b0};
        t3[3] = '{req: 1'b1, pop: 1'b1};
        t3[4] = '{req: 1'b0, pop: 1'b0};

        for (int c = 0; c < CH; c++) begin
            own[c] = 1'b0; mport[c] = 0;
            start_pk(c, 0, 4'd0, 4'd0);
        end

        // Reset with a body flit waiting: nothing may pop or drop.
        noc_rst_n = 1'b0;
        vc_valid  = 2'b11;
        vc_head   = 2'b00;
        vc_tail   = 2'b00;
        vc_dest_x = '0;
        vc_dest_y = '0;
        grant     = '0;
        #1;
        tick();
        tick();
        noc_rst_n = 1'b1;
        vc_valid  = 2'b00;
        tick();

        // Three-flit packet to (3,1) with grant held on EAST.
        start_pk(0, 3, 4'd3, 4'd1);
        grant = '0;
        grant[1][0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_pk();
            settle_check();
            chk("t1_sop", 32'(start_of_packet[1][0]), 32'(t1[i].sop));
            chk("t1_pop", 32'(vc_pop[0]),             32'(t1[i].pop));
            chk("t1_eop", 32'(end_of_packet[1][0]),   32'(t1[i].eop));
            chk("t1_free", 32'(free[1][0]),           32'(t1[i].eop));
            advance();
        end
        grant = '0;

        // Route sweep with single-flit packets.
        for (int i = 0; i < 4; i++) begin
            start_pk(0, 1, rt[i].dx, rt[i].dy);
            grant = '0;
            apply_pk();
            tick();
            apply_pk();
            grant[rt[i].port][0] = 1'b1;
            settle_check();
            chk("rt_port", 32'(vc_port[0]), 32'(rt[i].port));
            chk("rt_sop",  32'(start_of_packet[rt[i].port][0]), 32'd1);
            chk("rt_eop",  32'(end_of_packet[rt[i].port][0]),   32'd1);
            advance();
            grant = '0;
            apply_pk();
            tick();
        end

        // Single-flit packet to (2,2), grant only on cycle 3.
        start_pk(0, 1, 4'd2, 4'd2);
        for (int i = 0; i < 5; i++) begin
            grant = '0;
            if (i == 3) grant[1][0] = 1'b1;
            apply_pk();
            settle_check();
            chk("t3_req", 32'(request[1][0]),       32'(t3[i].req));
            chk("t3_pop", 32'(vc_pop[0]),           32'(t3[i].pop));
            chk("t3_eop", 32'(end_of_packet[1][0]), 32'(t3[i].pop));
            advance();
        end
        grant = '0;

        // Body flit while idle is dropped.
        start_pk(0, 0, 4'd0, 4'd0);
        vc_valid = 2'b01; vc_head = 2'b00; vc_tail = 2'b00;
        settle_check();
        chk("drop_pop", 32'(vc_pop[0]), 32'd1);
        chk("drop_o",   32'(drop_o[0]), 32'd1);
        advance();
        vc_valid = 2'b00;
        settle_check();
        chk("drop_nosop", 32'(start_of_packet), 32'd0);
        chk("drop_once",  32'(drop_o),          32'd0);
        advance();

        // Two VCs toward EAST with alternating grants.
        start_pk(0, 3, 4'd3, 4'd1);
        start_pk(1, 3, 4'd3, 4'd1);
        for (int i = 0; i < 10; i++) begin
            grant = '0;
            grant[1] = (i % 2 == 0) ? 2'b01 : 2'b10;
            apply_pk();
            settle_check();
            if (i == 1) chk("dual_sop", 32'(start_of_packet[1]), 32'd3);
            advance();
        end
        grant = '0;

        // Asynchronous reset in the middle of a packet.
        start_pk(0, 3, 4'd3, 4'd1);
        start_pk(1, 0, 4'd0, 4'd0);
        apply_pk();
        tick();
        apply_pk();
        tick();
        apply_pk();
        #2;
        noc_rst_n = 1'b0;
        #1;
        chk("rst_sop",  32'(start_of_packet), 32'd0);
        chk("rst_port", 32'(vc_port),         32'd0);
        chk("rst_req",  32'(request),         32'd0);
        chk("rst_pop",  32'(vc_pop),          32'd0);
        @(posedge noc_clk);
        #1;
        tick();
        noc_rst_n = 1'b1;
        apply_pk();
        tick();
        apply_pk();
        settle_check();
        chk("rst_resop", 32'(start_of_packet[1][0]), 32'd1);
        advance();
        grant[1][0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_pk();
            tick();
        end
        grant = '0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            vc_valid = 2'($urandom);
            vc_head  = 2'($urandom);
            vc_tail  = 2'($urandom);
            for (int c = 0; c < CH; c++) begin
                vc_dest_x[c] = 4'($urandom_range(0, 3));
                vc_dest_y[c] = 4'($urandom_range(0, 3));
            end
            grant = 10'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
